// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store controller.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_X
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Latched copy of the accepted decoder request.
  typedef struct packed {
    logic            store;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } ls_req_t;

  // Access width from funct3; SZ_X marks encodings with no RV32I load form.
  function automatic size_e access_size(input logic [2:0] funct3);
    size_e sz;
    case (funct3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      F3_W:        sz = SZ_W;
      default:     sz = SZ_X;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory port between the load/store controller and the memory.
interface lsu_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  mem_req;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension, and legality checks.
module lsu_align
  import lsu_pkg::*;
(
  input  logic            store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] ld_fmt,
  output logic            misalign,
  output logic            unsupported
);

  size_e       size;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    size        = access_size(funct3);
    rbyte       = 8'(rdata >> {addr_lo, 3'b000});
    rhalf       = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be          = '0;
    wdata_rep   = wdata;
    ld_fmt      = rdata;
    case (size)
      SZ_B: begin
        be        = BE_W'(4'b0001 << addr_lo);
        wdata_rep = {4{wdata[7:0]}};
        ld_fmt    = funct3[2] ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      SZ_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        ld_fmt    = funct3[2] ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      SZ_W: be = 4'b1111;
      default: be = '0;
    endcase
    misalign    = ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));
    // Stores have no unsigned forms, so funct3[2] is illegal for them.
    unsupported = (size == SZ_X) || (store && funct3[2]);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one decoded access, runs a req/ack memory
// transaction with timeout, and returns formatted load data to the register file.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ls_valid,
  input  logic                  ls_store,
  input  logic [2:0]            ls_funct3,
  input  logic [DATA_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  stall,
  output logic                  ld_we,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ls_err,
  lsu_ctrl_if.master            mem
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e          state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  ls_req_t         req_q;

  logic            al_store;
  logic [2:0]      al_funct3;
  logic [1:0]      al_addr_lo;
  logic [XLEN-1:0] al_wdata_in;
  logic [BE_W-1:0] al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ld;
  logic            misalign;
  logic            unsupported;
  logic            in_idle;
  logic            in_req;
  logic            st_active;

  assign in_idle   = (state == ST_IDLE);
  assign in_req    = (state == ST_REQ);
  assign st_active = in_req && req_q.store;

  // Legality is judged on the live request in IDLE; afterwards the latched copy drives the lanes.
  always_comb begin
    al_store    = req_q.store;
    al_funct3   = req_q.funct3;
    al_addr_lo  = req_q.addr[1:0];
    al_wdata_in = req_q.wdata;
    if (in_idle) begin
      al_store    = ls_store;
      al_funct3   = ls_funct3;
      al_addr_lo  = ls_addr[1:0];
      al_wdata_in = ls_wdata;
    end
  end

  lsu_align u_align (
    .store       (al_store),
    .funct3      (al_funct3),
    .addr_lo     (al_addr_lo),
    .wdata       (al_wdata_in),
    .rdata       (mem.mem_rdata),
    .be          (al_be),
    .wdata_rep   (al_wdata),
    .ld_fmt      (al_ld),
    .misalign    (misalign),
    .unsupported (unsupported)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (ls_valid) state_d = (misalign || unsupported) ? ST_ERR : ST_REQ;
      end
      ST_REQ: begin
        if (mem.mem_ack)           state_d = ST_RESP;
        else if (cnt == CNT_LAST)  state_d = ST_ERR;
        else                       cnt_d   = cnt + CNT_W'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (in_idle && ls_valid) begin
      req_q.store  <= ls_store;
      req_q.funct3 <= ls_funct3;
      req_q.addr   <= XLEN'(ls_addr);
      req_q.wdata  <= XLEN'(ls_wdata);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_data <= '0;
    end else if (in_req && mem.mem_ack && !req_q.store) begin
      ld_data <= DATA_WIDTH'(al_ld);
    end
  end

  assign stall         = (in_idle && ls_valid) || in_req;
  assign ld_we         = (state == ST_RESP) && !req_q.store;
  assign ls_err        = (state == ST_ERR);
  assign mem.mem_req   = in_req;
  assign mem.mem_addr  = DATA_WIDTH'({req_q.addr[XLEN-1:2], 2'b00});
  assign mem.mem_be    = st_active ? al_be : '0;
  assign mem.mem_wdata = st_active ? DATA_WIDTH'(al_wdata) : '0;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store controller between the instruction decoder and the data memory port of the RV32I core. It accepts one decoded load or store, runs a req/ack transaction with a wait-state memory, and formats load data for the register file. It stalls the core until the access completes, and it flags misaligned, unsupported or timed-out accesses.

## Interface
- DATA_WIDTH, 32: data and address width.
- TIMEOUT_CYCLES, 255: maximum cycles in REQ without mem_ack before an error; must be ≥ 1.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ls_valid  in  1  decoder presents a load/store this cycle.
- ls_store  in  1  1 = store, 0 = load.
- ls_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- ls_addr  in  DATA_WIDTH  effective address (rs1 + imm).
- ls_wdata  in  DATA_WIDTH  store source (rs2 value).
- stall  out  1  hold PC/instruction.
- ld_we  out  1  one-cycle register-file write strobe for load result.
- ld_data  out  DATA_WIDTH  formatted load result.
- ls_err  out  1  one-cycle pulse: misaligned, unsupported funct3, or timeout.
- mem_req  out  1  memory request.
- mem_addr  out  DATA_WIDTH  word-aligned address (low 2 bits 0).
- mem_be  out  4  byte write enables; 0000 for loads.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_ack  in  1  memory completes the request this cycle.
- mem_rdata  in  DATA_WIDTH  read word, valid with mem_ack.

## Operation
- States: IDLE, REQ, RESP, ERR.
- IDLE: on ls_valid, latch store, funct3, addr and wdata. A legal access goes to REQ. A misaligned or unsupported access goes to ERR and issues no memory access.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Unsupported: loads with funct3 011, 110 or 111; stores with funct3 ≥ 011.
- REQ: mem_req=1; mem_addr, mem_be and mem_wdata come from the latched values and are held stable.
  - On mem_ack: a load captures the formatted mem_rdata into ld_data; go to RESP.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT_CYCLES-1 with no ack, go to ERR.
  - If ack and the timeout limit occur in the same cycle, the ack wins.
- RESP: ld_we=1 for loads (0 for stores); go to IDLE.
- ERR: ls_err=1; ld_we=0; go to IDLE.
- Store lanes:
  - SB: mem_wdata = byte replicated ×4; mem_be = 0001 << addr[1:0].
  - SH: mem_wdata = halfword replicated ×2; mem_be = 0011 at offset 0, 1100 at offset 2.
  - SW: mem_be = 1111.
- Load format:
  - LB/LBU: byte lane addr[1:0], sign- or zero-extended to 32 bits.
  - LH/LHU: lane 0 or 2, sign- or zero-extended.
  - LW: word unchanged.
  - Upper bits are always fully defined.
- stall = ls_valid in IDLE, or state is REQ. It is 0 in RESP, in ERR, and in IDLE without ls_valid.
- mem_ack outside REQ is ignored. Changes to the ls_* inputs while not in IDLE are ignored.

## Timing
- Reset values: state IDLE; wait counter 0; ld_data 0; all registers cleared.
- Reset values of outputs: stall=0, ld_we=0, ls_err=0, mem_req=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-transaction drops mem_req immediately; the in-flight access is abandoned.
- All outputs except stall are registered-state decodes. stall is combinational from ls_valid and state.
- Minimum latency with zero-wait memory: cycle 0 IDLE/accept, cycle 1 REQ with ack, cycle 2 RESP. The core advances on the edge ending cycle 2, giving 3 cycles per access.
- With N wait states: 3+N cycles.
- Error path: IDLE then ERR = 2 cycles. Timeout: 2 + TIMEOUT_CYCLES cycles.
- Back-to-back: a new ls_valid is first accepted in the IDLE cycle after RESP or ERR.

## Structure
- Package lsu_pkg:
  - state enum;
  - funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101);
  - access-size decode function.
- Sub-module lsu_align: purely combinational.
  - Inputs: funct3, addr[1:0], wdata, rdata.
  - Outputs: mem_be, lane-replicated wdata, formatted load data, misalign, unsupported.
- lsu_ctrl holds the FSM, the input latch, the wait counter and the ld_data register.

## Test plan
- LW at 0x100, memory acks in the first REQ cycle with rdata 0xDEADBEEF -> stall high 2 cycles; RESP: ld_we=1, ld_data=0xDEADBEEF; mem_be=0000.
- LB at 0x103, rdata 0x80123456 -> ld_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x00008012.
- SH at 0x206, wdata 0x0000ABCD, ack after 3 wait cycles -> mem_addr=0x204, mem_be=1100, mem_wdata=0xABCDABCD held 4 REQ cycles; ld_we never asserted.
- SW at 0x101 -> ls_err pulses in cycle 1, mem_req never asserted, stall released in cycle 1.
- TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then ls_err=1 for one cycle, then IDLE. A separate run with ack in the 4th REQ cycle -> RESP and no error.
- rst_n pulled low during REQ -> mem_req and stall go to 0 without waiting for a clock. After release, a fresh LW completes normally.
